img_frame_capture: RTL and testbench

Sink-side receiver for the sobel output video stream (hsync/vsync/data/de). It converts the raster stream into linear frame-buffer write transactions and checks frame geometry against H_DISP × V_DISP. It reports per-frame completion and error status. It sits at the far end of the video pipeline and replaces direct VGA output during capture and verification.

---
 rtl/img_frame_capture.sv | 225 ++++++++++++++++++++++
 tb/tb_img_frame_capture.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_frame_capture.sv
`default_nettype none
// ============================================================================
// img_frame_capture : raster video sink -> linear frame-buffer writes with
// per-frame geometry checks. Optional macro CAPTURE_CHECKSUM_EN adds frame_sum.
// Revision: 1.0
// ============================================================================
module img_frame_capture #(
   parameter int H_DISP = 640,
   parameter int V_DISP = 480,
   parameter int AW     = 19
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          img_hsync,
   input  logic          img_vsync,
   input  logic [7:0]    img_data,
   input  logic          img_de,
   input  logic          capture_en,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [7:0]    wr_data,
   output logic          frame_done,
   output logic [15:0]   frame_cnt,
   output logic          err_line,
   output logic          err_frame,
`ifdef CAPTURE_CHECKSUM_EN
   output logic [31:0]   frame_sum,
`endif
   output logic          busy
);

   localparam int FRAME_PIX = H_DISP * V_DISP;
   localparam int PW        = $clog2(FRAME_PIX + 1);
   localparam int XW        = $clog2(H_DISP + 2);
   localparam int LW        = $clog2(V_DISP + 2);

   localparam logic [PW-1:0] PIX_FULL  = PW'(FRAME_PIX);
   localparam logic [XW-1:0] X_FULL    = XW'(H_DISP);
   localparam logic [XW-1:0] X_SAT     = XW'(H_DISP + 1);
   localparam logic [LW-1:0] LINE_FULL = LW'(V_DISP);
   localparam logic [LW-1:0] LINE_SAT  = LW'(V_DISP + 1);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      CAPTURE = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic          vs_q, de_q;
   logic [XW-1:0] x_q, x_d;
   logic [LW-1:0] lines_q, lines_d;
   logic [PW-1:0] pix_q, pix_d;
   logic          ovf_q, ovf_d;
   logic          lerr_q, lerr_d;
   logic          wr_en_q, wr_en_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic          frame_done_q, frame_done_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic          err_line_q, err_line_d;
   logic          err_frame_q, err_frame_d;
`ifdef CAPTURE_CHECKSUM_EN
   logic [31:0]   sum_q, sum_d;
   logic [31:0]   frame_sum_q, frame_sum_d;
`endif

   logic          fs, le;
   logic          lerr_close;
   logic [LW-1:0] lines_close;
   logic          start, take;
   logic          unused_hsync;

   // Line structure is recovered from de edges; hsync carries no extra information.
   assign unused_hsync = img_hsync;

   assign fs = img_vsync & ~vs_q;
   assign le = ~img_de & de_q;

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      lines_d      = lines_q;
      pix_d        = pix_q;
      ovf_d        = ovf_q;
      lerr_d       = lerr_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      err_line_d   = err_line_q;
      err_frame_d  = err_frame_q;
`ifdef CAPTURE_CHECKSUM_EN
      sum_d        = sum_q;
      frame_sum_d  = frame_sum_q;
`endif
      start        = 1'b0;
      take         = 1'b0;

      // A line end coincident with frame start still belongs to the closing frame.
      lerr_close  = lerr_q | (le & (x_q != X_FULL));
      lines_close = (le && (lines_q != LINE_SAT)) ? lines_q + LW'(1) : lines_q;

      unique case (state_q)
         IDLE: begin
            if (fs && capture_en) begin
               state_d = CAPTURE;
               start   = 1'b1;
            end
         end
         CAPTURE: begin
            if (fs) begin
               frame_done_d = 1'b1;
               frame_cnt_d  = frame_cnt_q + 16'd1;
               err_line_d   = lerr_close;
               err_frame_d  = ovf_q | (pix_q != PIX_FULL) | (lines_close != LINE_FULL);
`ifdef CAPTURE_CHECKSUM_EN
               frame_sum_d  = sum_q;
`endif
               if (capture_en) begin
                  start = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (le) begin
                  lines_d = lines_close;
                  lerr_d  = lerr_close;
                  x_d     = '0;
               end
               take = img_de;
            end
         end
         default: state_d = IDLE;
      endcase

      if (start) begin
         x_d     = '0;
         lines_d = '0;
         pix_d   = '0;
         ovf_d   = 1'b0;
         lerr_d  = 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
         sum_d   = '0;
`endif
         take    = img_de;
      end

      // x counts every valid pixel, dropped ones included, so line length stays honest.
      if (take) begin
         if (x_d != X_SAT) begin
            x_d = x_d + XW'(1);
         end
         if (pix_d != PIX_FULL) begin
            wr_en_d   = 1'b1;
            wr_addr_d = AW'(pix_d);
            wr_data_d = img_data;
            pix_d     = pix_d + PW'(1);
`ifdef CAPTURE_CHECKSUM_EN
            sum_d     = sum_d + 32'(img_data);
`endif
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         vs_q         <= 1'b0;
         de_q         <= 1'b0;
         x_q          <= '0;
         lines_q      <= '0;
         pix_q        <= '0;
         ovf_q        <= 1'b0;
         lerr_q       <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
         err_line_q   <= 1'b0;
         err_frame_q  <= 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
         sum_q        <= '0;
         frame_sum_q  <= '0;
`endif
      end else begin
         state_q      <= state_d;
         vs_q         <= img_vsync;
         de_q         <= img_de;
         x_q          <= x_d;
         lines_q      <= lines_d;
         pix_q        <= pix_d;
         ovf_q        <= ovf_d;
         lerr_q       <= lerr_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
         err_line_q   <= err_line_d;
         err_frame_q  <= err_frame_d;
`ifdef CAPTURE_CHECKSUM_EN
         sum_q        <= sum_d;
         frame_sum_q  <= frame_sum_d;
`endif
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;
   assign err_line   = err_line_q;
   assign err_frame  = err_frame_q;
   assign busy       = (state_q == CAPTURE);
`ifdef CAPTURE_CHECKSUM_EN
   assign frame_sum  = frame_sum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_img_frame_capture.sv
`default_nettype none
// ============================================================================
// tb_img_frame_capture : randomized raster frames checked against a frame-level
// reference model (H_DISP=8, V_DISP=4). Revision: 1.0
// ============================================================================
module tb_img_frame_capture;

   localparam int H    = 8;
   localparam int V    = 4;
   localparam int NPIX = H * V;
   localparam int AW   = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          img_hsync = 1'b0;
   logic          img_vsync = 1'b0;
   logic [7:0]    img_data = 8'h00;
   logic          img_de = 1'b0;
   logic          capture_en = 1'b0;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          frame_done;
   logic [15:0]   frame_cnt;
   logic          err_line;
   logic          err_frame;
   logic          busy;
`ifdef CAPTURE_CHECKSUM_EN
   logic [31:0]   frame_sum;
`endif

   always #5 clk = ~clk;

   img_frame_capture #(.H_DISP(H), .V_DISP(V), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .img_hsync  (img_hsync),
      .img_vsync  (img_vsync),
      .img_data   (img_data),
      .img_de     (img_de),
      .capture_en (capture_en),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt),
      .err_line   (err_line),
      .err_frame  (err_frame),
`ifdef CAPTURE_CHECKSUM_EN
      .frame_sum  (frame_sum),
`endif
      .busy       (busy)
   );

   typedef struct packed {
      logic [AW-1:0] a;
      logic [7:0]    d;
   } wr_t;

   typedef struct packed {
      logic [15:0] cnt;
      logic        el;
      logic        ef;
      logic [31:0] sum;
   } cl_t;

   int            checks = 0;
   int            errors = 0;
   int            n_wr = 0;
   int            n_done = 0;
   wr_t           exp_wr[$];
   cl_t           exp_cl[$];
   logic [AW-1:0] wr_log[$];
   wr_t           mon_w;
   cl_t           mon_c;

   // Reference model state: frames are described as lists of line lengths.
   bit            m_cap, m_pvs, m_pde;
   int            m_lens[$];
   int            m_cur, m_pix;
   logic [31:0]   m_sum;
   logic [15:0]   m_cnt;
   bit            use_pat;
   int            pat;
   bit            cen;

   task automatic close_frame();
      int  total;
      bit  el;
      cl_t c;
      total = 0;
      el    = 1'b0;
      foreach (m_lens[i]) begin
         total += m_lens[i];
         if (m_lens[i] != H) el = 1'b1;
      end
      m_cnt = m_cnt + 16'd1;
      c.cnt = m_cnt;
      c.el  = el;
      c.ef  = (total != NPIX) || (m_lens.size() != V);
      c.sum = m_sum;
      exp_cl.push_back(c);
   endtask

   task automatic model_reset();
      exp_wr.delete();
      exp_cl.delete();
      m_lens.delete();
      m_cap = 1'b0;
      m_pvs = 1'b0;
      m_pde = 1'b0;
      m_cur = 0;
      m_pix = 0;
      m_sum = '0;
      m_cnt = '0;
   endtask

   task automatic tick(input bit vs, input bit hs, input bit de, input logic [7:0] d);
      bit  fs, le;
      wr_t w;
      @(negedge clk);
      img_vsync  = vs;
      img_hsync  = hs;
      img_de     = de;
      img_data   = d;
      capture_en = cen;
      fs = vs && !m_pvs;
      le = !de && m_pde;
      if (fs) begin
         if (m_cap) begin
            if (le) m_lens.push_back(m_cur);
            close_frame();
         end
         m_cap = cen;
         m_lens.delete();
         m_cur = 0;
         m_pix = 0;
         m_sum = '0;
      end else if (m_cap && le) begin
         m_lens.push_back(m_cur);
         m_cur = 0;
      end
      if (m_cap && de) begin
         m_cur++;
         if (m_pix < NPIX) begin
            w.a = AW'(m_pix);
            w.d = d;
            exp_wr.push_back(w);
            m_sum += 32'(d);
            m_pix++;
         end
      end
      m_pvs = vs;
      m_pde = de;
   endtask

   function automatic logic [7:0] dat();
      logic [7:0] r;
      if (use_pat) begin
         r = 8'(pat);
         pat++;
      end else begin
         r = 8'($urandom);
      end
      return r;
   endfunction

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_frame(input int lens[$], input bit cap, input bit de_at_fs);
      pat = 0;
      cen = cap;
      for (int l = 0; l < lens.size(); l++) begin
         int n;
         n = lens[l];
         if (l == 0 && de_at_fs) begin
            tick(1'b1, 1'b0, 1'b1, dat());
            n--;
         end else begin
            if (l == 0) tick(1'b1, 1'b0, 1'b0, 8'h00);
            tick(1'b0, 1'b1, 1'b0, 8'h00);
            tick(1'b0, 1'b0, 1'b0, 8'h00);
         end
         repeat (n) tick(1'b0, 1'b0, 1'b1, dat());
      end
      idle(2);
   endtask

   // Write and frame-close scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_en) begin
            n_wr++;
            wr_log.push_back(wr_addr);
            checks++;
            if (exp_wr.size() == 0) begin
               errors++;
               $display("FAIL wr_unexpected got addr=%0d data=%0h expected no write", wr_addr, wr_data);
            end else begin
               mon_w = exp_wr.pop_front();
               if (wr_addr !== mon_w.a || wr_data !== mon_w.d) begin
                  errors++;
                  $display("FAIL wr_stream got addr=%0d data=%0h expected addr=%0d data=%0h",
                           wr_addr, wr_data, mon_w.a, mon_w.d);
               end
            end
         end
         if (frame_done) begin
            n_done++;
            checks++;
            if (exp_cl.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected got frame_done=1 expected 0");
            end else begin
               mon_c = exp_cl.pop_front();
               if (frame_cnt !== mon_c.cnt || err_line !== mon_c.el || err_frame !== mon_c.ef) begin
                  errors++;
                  $display("FAIL frame_close got cnt=%0h el=%0b ef=%0b expected cnt=%0h el=%0b ef=%0b",
                           frame_cnt, err_line, err_frame, mon_c.cnt, mon_c.el, mon_c.ef);
               end
`ifdef CAPTURE_CHECKSUM_EN
               checks++;
               if (frame_sum !== mon_c.sum) begin
                  errors++;
                  $display("FAIL frame_sum got %0d expected %0d", frame_sum, mon_c.sum);
               end
`endif
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({wr_en, wr_addr, wr_data, frame_done, frame_cnt, err_line, err_frame, busy} !== '0) begin
         errors++;
         $display("FAIL reset_values got en=%0b addr=%0d data=%0h done=%0b cnt=%0h el=%0b ef=%0b busy=%0b expected all 0",
                  wr_en, wr_addr, wr_data, frame_done, frame_cnt, err_line, err_frame, busy);
      end
`ifdef CAPTURE_CHECKSUM_EN
      checks++;
      if (frame_sum !== 32'd0) begin
         errors++;
         $display("FAIL reset_sum got %0d expected 0", frame_sum);
      end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_nominal();
      int L[$];
      int w0, d0;
      L = '{H, H, H, H};
      use_pat = 1'b1;
      w0 = n_wr;
      d0 = n_done;
      send_frame(L, 1'b1, 1'b0);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL nominal_busy got %0b expected 1", busy);
      end
      send_frame(L, 1'b1, 1'b0);
      checks++;
      if (frame_cnt !== 16'd1) begin
         errors++;
         $display("FAIL nominal_cnt1 got %0d expected 1", frame_cnt);
      end
      send_frame(L, 1'b0, 1'b0);
      checks++;
      if (n_wr - w0 != 2 * NPIX || n_done - d0 != 2) begin
         errors++;
         $display("FAIL nominal_counts got writes=%0d dones=%0d expected writes=%0d dones=2",
                  n_wr - w0, n_done - d0, 2 * NPIX);
      end
      checks++;
      if (frame_cnt !== 16'd2 || err_line !== 1'b0 || err_frame !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL nominal_final got cnt=%0d el=%0b ef=%0b busy=%0b expected cnt=2 el=0 ef=0 busy=0",
                  frame_cnt, err_line, err_frame, busy);
      end
`ifdef CAPTURE_CHECKSUM_EN
      checks++;
      if (frame_sum !== 32'd496) begin
         errors++;
         $display("FAIL nominal_sum got %0d expected 496", frame_sum);
      end
`endif
      use_pat = 1'b0;
   endtask

   task automatic test_idle_gating();
      int L[$];
      int w0, d0, k;
      L = '{H, H, H, H};
      w0 = n_wr;
      d0 = n_done;
      send_frame(L, 1'b0, 1'b0);
      checks++;
      if (n_wr != w0 || busy !== 1'b0 || n_done != d0) begin
         errors++;
         $display("FAIL idle_gate got writes=%0d busy=%0b dones=%0d expected writes=0 busy=0 dones=0",
                  n_wr - w0, busy, n_done - d0);
      end
      k = wr_log.size();
      send_frame(L, 1'b1, 1'b0);
      send_frame(L, 1'b0, 1'b0);
      checks++;
      if (wr_log.size() <= k || wr_log[k] !== '0 || n_wr - w0 != NPIX) begin
         errors++;
         $display("FAIL idle_start got writes=%0d first_addr=%0d expected writes=%0d first_addr=0",
                  n_wr - w0, (wr_log.size() > k) ? int'(wr_log[k]) : -1, NPIX);
      end
   endtask

   task automatic test_short_line();
      int S[$];
      int L[$];
      S = '{H, H, 7, H};
      L = '{H, H, H, H};
      send_frame(S, 1'b1, 1'b0);
      send_frame(L, 1'b1, 1'b0);
      checks++;
      if (err_line !== 1'b1 || err_frame !== 1'b1 || frame_cnt !== m_cnt) begin
         errors++;
         $display("FAIL short_line got el=%0b ef=%0b cnt=%0d expected el=1 ef=1 cnt=%0d",
                  err_line, err_frame, frame_cnt, m_cnt);
      end
      send_frame(L, 1'b0, 1'b0);
      checks++;
      if (err_line !== 1'b0 || err_frame !== 1'b0) begin
         errors++;
         $display("FAIL short_recover got el=%0b ef=%0b expected el=0 ef=0", err_line, err_frame);
      end
   endtask

   task automatic test_overflow();
      int O[$];
      int L[$];
      int w0;
      O = '{H, H, H, H, H};
      L = '{H, H, H, H};
      w0 = n_wr;
      send_frame(O, 1'b1, 1'b0);
      send_frame(L, 1'b0, 1'b0);
      checks++;
      if (n_wr - w0 != NPIX || wr_log[$] !== AW'(NPIX - 1)) begin
         errors++;
         $display("FAIL overflow_writes got writes=%0d last=%0d expected writes=%0d last=%0d",
                  n_wr - w0, wr_log[$], NPIX, NPIX - 1);
      end
      checks++;
      if (err_frame !== 1'b1 || err_line !== 1'b0) begin
         errors++;
         $display("FAIL overflow_err got el=%0b ef=%0b expected el=0 ef=1", err_line, err_frame);
      end
   endtask

   task automatic test_de_at_fs();
      int L[$];
      int k;
      L = '{H, H, H, H};
      k = wr_log.size();
      send_frame(L, 1'b1, 1'b1);
      send_frame(L, 1'b0, 1'b0);
      checks++;
      if (wr_log.size() <= k || wr_log[k] !== '0 || err_frame !== 1'b0 || err_line !== 1'b0) begin
         errors++;
         $display("FAIL de_at_fs got first_addr=%0d el=%0b ef=%0b expected first_addr=0 el=0 ef=0",
                  (wr_log.size() > k) ? int'(wr_log[k]) : -1, err_line, err_frame);
      end
   endtask

   task automatic test_async_reset();
      int L[$];
      int d0;
      L = '{H, H, H, H};
      cen = 1'b1;
      tick(1'b1, 1'b0, 1'b0, 8'h00);
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      repeat (3) tick(1'b0, 1'b0, 1'b1, dat());
      @(posedge clk);
      #2;
      rst_n      = 1'b0;
      img_de     = 1'b0;
      img_vsync  = 1'b0;
      img_hsync  = 1'b0;
      img_data   = 8'h00;
      model_reset();
      #1;
      checks++;
      if ({wr_en, wr_addr, wr_data, frame_done, frame_cnt, err_line, err_frame, busy} !== '0) begin
         errors++;
         $display("FAIL async_reset got en=%0b addr=%0d data=%0h done=%0b cnt=%0h el=%0b ef=%0b busy=%0b expected all 0",
                  wr_en, wr_addr, wr_data, frame_done, frame_cnt, err_line, err_frame, busy);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      d0 = n_done;
      send_frame(L, 1'b1, 1'b0);
      checks++;
      if (n_done != d0) begin
         errors++;
         $display("FAIL reset_no_done got dones=%0d expected 0", n_done - d0);
      end
      send_frame(L, 1'b0, 1'b0);
      checks++;
      if (frame_cnt !== 16'd1 || n_done - d0 != 1) begin
         errors++;
         $display("FAIL reset_restart got cnt=%0d dones=%0d expected cnt=1 dones=1", frame_cnt, n_done - d0);
      end
   endtask

   task automatic test_wrap();
      int L[$];
      L = '{H, H, H, H};
      send_frame(L, 1'b1, 1'b0);
      force dut.frame_cnt_q = 16'hFFFF;
      repeat (2) @(posedge clk);
      #1;
      release dut.frame_cnt_q;
      m_cnt = 16'hFFFF;
      send_frame(L, 1'b0, 1'b0);
      checks++;
      if (frame_cnt !== 16'h0000) begin
         errors++;
         $display("FAIL wrap_cnt got %0h expected 0000", frame_cnt);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      use_pat = 1'b0;
      cen     = 1'b0;
      pat     = 0;
      test_reset();
      test_nominal();
      test_idle_gating();
      test_short_line();
      test_overflow();
      test_de_at_fs();
      test_async_reset();
      test_wrap();
      idle(3);
      checks++;
      if (exp_wr.size() != 0 || exp_cl.size() != 0) begin
         errors++;
         $display("FAIL drain got pending_writes=%0d pending_closes=%0d expected 0 and 0",
                  exp_wr.size(), exp_cl.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
